// File: rtl/bin_to_bcd_if.sv
// Request/result bundle between an ALU-side producer and the binary-to-BCD converter.
// Master drives the operand and start; slave returns status and the held BCD result.
interface bin_to_bcd_if #(
    parameter int IN_WIDTH = 8
);
    logic                start;
    logic [IN_WIDTH-1:0] binary_in;
    logic                signed_mode;
    logic                busy;
    logic                done;
    logic [11:0]         twelve_bit_number;
    logic                negative;

    modport master (
        output start, binary_in, signed_mode,
        input  busy, done, twelve_bit_number, negative
    );

    modport slave (
        input  start, binary_in, signed_mode,
        output busy, done, twelve_bit_number, negative
    );
endinterface

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: signed/unsigned binary to three BCD digits.
// Latency: IN_WIDTH shift cycles after the start edge, then a one-cycle done pulse.
// No backpressure: start is only sampled in IDLE and dropped otherwise; result holds until next done.
module bin_to_bcd #(
    parameter int IN_WIDTH = 8
) (
    input  logic   clock,
    input  logic   reset_n,
    bin_to_bcd_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [3:0]        CNT_LOAD = 4'(IN_WIDTH);
    localparam logic [IN_WIDTH:0] ONE      = {{IN_WIDTH{1'b0}}, 1'b1};

    state_t              state;
    state_t              state_nxt;

    logic [IN_WIDTH-1:0] mag_q;
    logic [11:0]         scratch_q;
    logic [3:0]          cnt_q;
    logic                sign_q;
    logic [11:0]         bcd_q;
    logic                neg_q;

    logic                sign_in;
    logic [IN_WIDTH:0]   mag_full;
    logic [11:0]         scratch_adj;
    logic [11:0]         scratch_nxt;
    logic [IN_WIDTH-1:0] mag_nxt;

    // One bit wider than the operand so the most negative input negates to its true magnitude.
    always_comb begin
        sign_in  = bus.signed_mode & bus.binary_in[IN_WIDTH-1];
        mag_full = sign_in ? (~{1'b1, bus.binary_in} + ONE) : {1'b0, bus.binary_in};
    end

    always_comb begin
        scratch_adj = scratch_q;
        for (int d = 0; d < 3; d++) begin
            if (scratch_q[d*4 +: 4] >= 4'd5) begin
                scratch_adj[d*4 +: 4] = scratch_q[d*4 +: 4] + 4'd3;
            end
        end
        // Rotate rather than shift: the bit leaving the hundreds digit is always 0 for IN_WIDTH <= 9.
        scratch_nxt = {scratch_adj[10:0], mag_q[IN_WIDTH-1]};
        mag_nxt     = {mag_q[IN_WIDTH-2:0], scratch_adj[11]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = bus.start ? SHIFT : IDLE;
            SHIFT:   state_nxt = (cnt_q <= 4'd1) ? DONE : SHIFT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            SHIFT:   bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
        bus.twelve_bit_number = bcd_q;
        bus.negative          = neg_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mag_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mag_q     <= mag_full[IN_WIDTH-1:0];
                        // Top magnitude bit is always 0 here, so this clears the scratch digits.
                        scratch_q <= {11'd0, mag_full[IN_WIDTH]};
                        cnt_q     <= CNT_LOAD;
                        sign_q    <= sign_in;
                    end
                end
                SHIFT: begin
                    mag_q     <= mag_nxt;
                    scratch_q <= scratch_nxt;
                    cnt_q     <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        bcd_q <= scratch_nxt;
                        neg_q <= sign_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed bench for bin_to_bcd (IN_WIDTH=8) with an arithmetic reference model
// compared against the DUT outputs on every falling clock edge.
module tb_bin_to_bcd;
    localparam int W = 8;

    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    bin_to_bcd_if #(.IN_WIDTH(W)) bus ();

    bin_to_bcd #(.IN_WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_bcd(input logic [W-1:0] v, input logic sm);
        int s;
        int m;
        s = int'(v);
        if (sm && v[W-1]) s = s - (1 << W);
        m = (s < 0) ? -s : s;
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Reference model: cycles of shifting left, done flag, and the held result.
    int          m_left;
    bit          m_done;
    logic [11:0] m_res;
    logic [11:0] m_pend;
    bit          m_neg;
    bit          m_pend_neg;

    initial begin
        m_left = 0; m_done = 0; m_res = '0; m_pend = '0; m_neg = 0; m_pend_neg = 0;
    end

    always @(negedge reset_n) begin
        m_left = 0; m_done = 0; m_res = '0; m_neg = 0;
    end

    always @(posedge clock) begin
        if (reset_n === 1'b1) begin
            if (m_done) begin
                m_done = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_res  = m_pend;
                    m_neg  = m_pend_neg;
                end
            end else if (bus.start) begin
                m_pend     = model_bcd(bus.binary_in, bus.signed_mode);
                m_pend_neg = bus.signed_mode && bus.binary_in[W-1];
                m_left     = W;
            end
        end
    end

    always @(negedge clock) begin
        check("cyc_busy", int'(bus.busy), int'(m_left > 0));
        check("cyc_done", int'(bus.done), int'(m_done));
        check("cyc_bcd", int'(bus.twelve_bit_number), int'(m_res));
        check("cyc_neg", int'(bus.negative), int'(m_neg));
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic convert(input logic [W-1:0] v, input logic sm,
                           input logic [11:0] exp_bcd, input logic exp_neg, input string name);
        int busy_cyc;
        bit seen;
        busy_cyc = 0;
        seen     = 0;
        bus.binary_in   = v;
        bus.signed_mode = sm;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (bus.done) seen = 1;
            else if (bus.busy) busy_cyc++;
        end
        check({name, "_done_seen"}, int'(seen), 1);
        check({name, "_busy_len"}, busy_cyc, W);
        check({name, "_bcd"}, int'(bus.twelve_bit_number), int'(exp_bcd));
        check({name, "_neg"}, int'(bus.negative), int'(exp_neg));
        step();
    endtask

    initial begin
        int ndone;
        int last;
        total = 0;
        bad   = 0;
        reset_n         = 1'b0;
        bus.start       = 1'b0;
        bus.binary_in   = '0;
        bus.signed_mode = 1'b0;

        check("model_pin_80s", int'(model_bcd(8'h80, 1'b1)), 12'h128);
        check("model_pin_9cs", int'(model_bcd(8'h9C, 1'b1)), 12'h100);

        #3;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_bcd", int'(bus.twelve_bit_number), 0);
        check("reset_neg", int'(bus.negative), 0);
        repeat (3) step();
        reset_n = 1'b1;
        step();

        convert(8'd255, 1'b0, 12'h255, 1'b0, "u255");
        convert(8'h80,  1'b1, 12'h128, 1'b1, "s80");
        convert(8'hFF,  1'b1, 12'h001, 1'b1, "sff");
        convert(8'hFF,  1'b0, 12'h255, 1'b0, "uff");
        convert(8'd0,   1'b0, 12'h000, 1'b0, "u0");
        convert(8'd99,  1'b0, 12'h099, 1'b0, "u99");
        convert(8'd100, 1'b0, 12'h100, 1'b0, "u100");
        convert(8'd127, 1'b1, 12'h127, 1'b0, "s127");

        // Operand and mode change plus start re-pulse while busy.
        bus.binary_in   = 8'hF6;
        bus.signed_mode = 1'b0;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.binary_in   = 8'd37;
        bus.signed_mode = 1'b1;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.done) ndone++;
        end
        check("inflight_done_cnt", ndone, 1);
        check("inflight_bcd", int'(bus.twelve_bit_number), 12'h246);
        check("inflight_neg", int'(bus.negative), 0);
        step();

        convert(8'h9C, 1'b1, 12'h100, 1'b1, "s9c");

        // Reset on the 4th shift cycle.
        bus.binary_in   = 8'd200;
        bus.signed_mode = 1'b0;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        check("pre_abort_busy", int'(bus.busy), 1);
        reset_n = 1'b0;
        #1;
        check("abort_bcd", int'(bus.twelve_bit_number), 0);
        check("abort_neg", int'(bus.negative), 0);
        check("abort_busy", int'(bus.busy), 0);
        repeat (2) step();
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (bus.done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        step();
        convert(8'd42, 1'b0, 12'h042, 1'b0, "u42");

        // Start held high: conversions back to back.
        bus.binary_in   = 8'd58;
        bus.signed_mode = 1'b0;
        bus.start       = 1'b1;
        ndone = 0;
        last  = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus.done) begin
                if (last >= 0) check("hold_spacing", c - last, W + 2);
                check("hold_bcd", int'(bus.twelve_bit_number), 12'h058);
                last = c;
                ndone++;
            end
        end
        check("hold_done_cnt", ndone, 4);
        step();
        bus.start = 1'b0;
        repeat (12) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 Parameter IN_WIDTH, default 8, binary input width; legal range 4..9 so that the magnitude always fits three BCD digits.
REQ-002 Port clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port start  input  1  conversion request; sampled only in IDLE.
REQ-005 Port binary_in  input  IN_WIDTH  operand, typically the ALU result.
REQ-006 Port signed_mode  input  1  1 = interpret binary_in as two's complement; 0 = unsigned.
REQ-007 Port busy  output  1  high while a conversion is in progress.
REQ-008 Port done  output  1  one-cycle pulse marking a fresh result.
REQ-009 Port twelve_bit_number  output  12  BCD result: [11:8] hundreds, [7:4] tens, [3:0] units; feeds the display-multiplex FSM directly.
REQ-010 Port negative  output  1  sign of the last converted operand; high only in signed mode with a negative operand.

Function
REQ-011 The block SHALL implement a registered three-state FSM with states IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL perform all of the following on that edge (E0):
- latch binary_in and signed_mode;
- load the magnitude into the shift register;
- clear the BCD scratch register;
- load the bit counter with IN_WIDTH;
- go to SHIFT.
REQ-013 Magnitude SHALL be binary_in when signed_mode=0 or binary_in MSB=0; otherwise it SHALL be the two's-complement negation, computed IN_WIDTH+1 bits wide so the most negative value (for example 8'h80) yields 128.
REQ-014 In SHIFT, each edge SHALL perform one double-dabble step:
- add 3 to every scratch digit >= 5;
- shift {scratch, magnitude} left by one bit;
- decrement the counter.
REQ-015 On the edge that completes the IN_WIDTH-th shift (E0+IN_WIDTH), the block SHALL:
- load twelve_bit_number from the scratch register;
- load negative with the latched sign;
- go to DONE.
REQ-016 done SHALL be high exactly while in DONE, i.e. one cycle; DONE SHALL return to IDLE unconditionally on the next edge.
REQ-017 busy SHALL be high exactly while in SHIFT (IN_WIDTH cycles).
REQ-018 start SHALL be ignored in SHIFT and DONE; no request queuing.
REQ-019 Changes on binary_in or signed_mode after E0 SHALL NOT affect the conversion in flight.
REQ-020 With start held high continuously, a conversion SHALL begin every IN_WIDTH+2 cycles.
REQ-021 twelve_bit_number and negative SHALL hold their last value between conversions, including during SHIFT, so the display never shows partial results.
REQ-022 Every output digit SHALL be in range 0..9.
REQ-023 Any unreachable state encoding SHALL return to IDLE on the next edge with outputs unchanged.

Reset
REQ-024 reset_n=0 SHALL asynchronously force all of the following:
- state IDLE;
- busy=0 and done=0;
- twelve_bit_number=12'h000 and negative=0;
- counter and scratch registers to 0.
REQ-025 Reset asserted mid-conversion SHALL abort it; no done pulse SHALL follow for that request.
REQ-026 After reset_n deasserts, the first start sampled high in IDLE SHALL begin a normal conversion.

Verification (IN_WIDTH=8)
REQ-027 Unsigned 8'd255, start for 1 cycle -> busy for 8 cycles, then done for 1 cycle with twelve_bit_number=12'h255 and negative=0.
REQ-028 Signed 8'h80 -> twelve_bit_number=12'h128, negative=1; signed 8'hFF -> 12'h001, negative=1; unsigned 8'hFF -> 12'h255, negative=0.
REQ-029 8'd0 -> 12'h000; 8'd99 -> 12'h099; 8'd100 -> 12'h100.
REQ-030 binary_in changed and start re-pulsed during busy -> result reflects only the original operand; a single done pulse.
REQ-031 reset_n low on the 4th SHIFT cycle -> outputs read 0 immediately and no done pulse; a subsequent start with 8'd42 -> 12'h042.
REQ-032 start held high for 40 cycles -> done pulses spaced exactly 10 cycles apart.
